// File: rtl/riscv_pkg.sv
// Shared definitions for the RV32I pipeline: ALU operation codes and
// operand-forwarding select codes used by the execute stage.
package riscv_pkg;

   // ALU operation codes carried on ALUControlE
   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   // Forwarding selects driven by the hazard unit
   localparam logic [1:0] FWD_RF  = 2'b00;
   localparam logic [1:0] FWD_WB  = 2'b01;
   localparam logic [1:0] FWD_MEM = 2'b10;

   // Operand selection shared by both forwarding muxes. The unused code 11
   // falls back to the register-file value, same as 00.
   function automatic logic [31:0] selectOperand(
      input logic [1:0]  sel,
      input logic [31:0] regFileVal,
      input logic [31:0] writebackVal,
      input logic [31:0] memStageVal
   );
      case (sel)
         FWD_WB:  return writebackVal;
         FWD_MEM: return memStageVal;
         default: return regFileVal;
      endcase
   endfunction

endpackage

// File: rtl/execute_stage_if.sv
// Bundle of execute-stage inputs (from ID/EX and the hazard unit) and the
// outputs it returns (fetch redirect plus the EX/MEM register contents).
interface execute_stage_if #(
   parameter int XLEN = 32
);
   // Control bits from ID/EX
   logic            RegWriteE;
   logic            ResultSrcE;
   logic            MemWriteE;
   logic            BranchE;
   logic            JumpE;
   logic            ALUSrcE;
   logic [2:0]      ALUControlE;

   // Datapath from ID/EX
   logic [XLEN-1:0] RD1E;
   logic [XLEN-1:0] RD2E;
   logic [XLEN-1:0] ImmExtE;
   logic [XLEN-1:0] PCE;
   logic [XLEN-1:0] PCPlus4E;
   logic [4:0]      RdE;

   // Forwarding controls and writeback bypass value
   logic [1:0]      ForwardAE;
   logic [1:0]      ForwardBE;
   logic [XLEN-1:0] ResultW;

   // Combinational redirect back to fetch
   logic            PCSrcE;
   logic [XLEN-1:0] PCTargetE;

   // EX/MEM register outputs toward the memory stage
   logic            RegWriteM;
   logic            ResultSrcM;
   logic            MemWriteM;
   logic [XLEN-1:0] ALUResultM;
   logic [XLEN-1:0] WriteDataM;
   logic [XLEN-1:0] PCPlus4M;
   logic [4:0]      RdM;

   // Upstream side: drives E inputs, observes redirect and M outputs
   modport master (
      output RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE, ALUSrcE,
             ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE,
             ForwardAE, ForwardBE, ResultW,
      input  PCSrcE, PCTargetE, RegWriteM, ResultSrcM, MemWriteM,
             ALUResultM, WriteDataM, PCPlus4M, RdM
   );

   // Execute stage side
   modport slave (
      input  RegWriteE, ResultSrcE, MemWriteE, BranchE, JumpE, ALUSrcE,
             ALUControlE, RD1E, RD2E, ImmExtE, PCE, PCPlus4E, RdE,
             ForwardAE, ForwardBE, ResultW,
      output PCSrcE, PCTargetE, RegWriteM, ResultSrcM, MemWriteM,
             ALUResultM, WriteDataM, PCPlus4M, RdM
   );

endinterface

// File: rtl/execute_stage_alu.sv
// Combinational RV32I ALU: ADD, SUB, AND, OR and signed SLT. Undefined
// operation codes produce 0 so a stray code cannot leak stale data.
module alu
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic [2:0]      aluControl,
   output logic [XLEN-1:0] result,
   output logic            zero
);

   logic lessThan;

   assign lessThan = $signed(a) < $signed(b);

   // Operation decode; ADD/SUB wrap modulo 2^XLEN with no flags
   always_comb begin
      result = '0;
      case (aluControl)
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_SLT: result = {{(XLEN-1){1'b0}}, lessThan};
         default: result = '0;
      endcase
   end

   assign zero = (result == '0);

endmodule

// File: rtl/execute_stage.sv
// Execute stage of the 5-stage RV32I pipeline: forwarding muxes, ALU,
// branch/jump resolution, target adder and the EX/MEM pipeline register.
// The register updates on the falling clock edge like the rest of the core,
// and an asynchronous active-low reset turns it into a bubble.
module execute_stage
   import riscv_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic          clk,
   input  logic          rst,
   execute_stage_if.slave bus
);

   logic [XLEN-1:0] srcA;
   logic [XLEN-1:0] writeDataE;
   logic [XLEN-1:0] srcB;
   logic [XLEN-1:0] aluResultE;
   logic            zeroE;

   // EX/MEM register contents
   logic            regWriteMReg;
   logic            resultSrcMReg;
   logic            memWriteMReg;
   logic [XLEN-1:0] aluResultMReg;
   logic [XLEN-1:0] writeDataMReg;
   logic [XLEN-1:0] pcPlus4MReg;
   logic [4:0]      rdMReg;

   // Forwarding: the MEM-stage bypass uses the value currently held in the
   // EX/MEM register, i.e. the result of the immediately preceding instruction
   always_comb begin
      srcA       = selectOperand(bus.ForwardAE, bus.RD1E, bus.ResultW, aluResultMReg);
      writeDataE = selectOperand(bus.ForwardBE, bus.RD2E, bus.ResultW, aluResultMReg);
      srcB       = bus.ALUSrcE ? bus.ImmExtE : writeDataE;
   end

   alu #(
      .XLEN (XLEN)
   ) aluInst (
      .a          (srcA),
      .b          (srcB),
      .aluControl (bus.ALUControlE),
      .result     (aluResultE),
      .zero       (zeroE)
   );

   // Branch target wraps naturally; redirect is taken for JAL or a BEQ hit
   assign bus.PCTargetE = bus.PCE + bus.ImmExtE;
   assign bus.PCSrcE    = bus.JumpE | (bus.BranchE & zeroE);

   // EX/MEM register: falling-edge capture, async clear drops the in-flight op
   always_ff @(negedge clk or negedge rst) begin
      if (!rst) begin
         regWriteMReg  <= 1'b0;
         resultSrcMReg <= 1'b0;
         memWriteMReg  <= 1'b0;
         aluResultMReg <= '0;
         writeDataMReg <= '0;
         pcPlus4MReg   <= '0;
         rdMReg        <= '0;
      end else begin
         regWriteMReg  <= bus.RegWriteE;
         resultSrcMReg <= bus.ResultSrcE;
         memWriteMReg  <= bus.MemWriteE;
         aluResultMReg <= aluResultE;
         writeDataMReg <= writeDataE;
         pcPlus4MReg   <= bus.PCPlus4E;
         rdMReg        <= bus.RdE;
      end
   end

   assign bus.RegWriteM  = regWriteMReg;
   assign bus.ResultSrcM = resultSrcMReg;
   assign bus.MemWriteM  = memWriteMReg;
   assign bus.ALUResultM = aluResultMReg;
   assign bus.WriteDataM = writeDataMReg;
   assign bus.PCPlus4M   = pcPlus4MReg;
   assign bus.RdM        = rdMReg;

endmodule

// File: tb/tb_execute_stage.sv
// Directed plus randomized checks of execute_stage against a behavioural
// model of the execute stage and its EX/MEM register.
module tb_execute_stage;

   logic clk = 1'b0;
   logic rst = 1'b0;

   always #5 clk = ~clk;

   execute_stage_if #(.XLEN(32)) bus ();

   execute_stage #(.XLEN(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int errors = 0;
   int checks = 0;

   // Model of the EX/MEM register contents
   logic        mRegWrite, mResultSrc, mMemWrite;
   logic [31:0] mAluResult, mWriteData, mPcPlus4;
   logic [4:0]  mRd;

   function automatic logic [31:0] refAlu(input logic [2:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
      int sa;
      int sb;
      sa = a;
      sb = b;
      case (op)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd5:    return (sa < sb) ? 32'd1 : 32'd0;
         default: return 32'd0;
      endcase
   endfunction

   function automatic logic [31:0] refFwd(input logic [1:0] sel,
                                          input logic [31:0] rf,
                                          input logic [31:0] wb,
                                          input logic [31:0] mem);
      if (sel == 2'd1) return wb;
      if (sel == 2'd2) return mem;
      return rf;
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic modelClear();
      mRegWrite  = 1'b0;
      mResultSrc = 1'b0;
      mMemWrite  = 1'b0;
      mAluResult = '0;
      mWriteData = '0;
      mPcPlus4   = '0;
      mRd        = '0;
   endtask

   task automatic checkM(input string tag);
      check({tag, "/RegWriteM"},  32'(bus.RegWriteM),  32'(mRegWrite));
      check({tag, "/ResultSrcM"}, 32'(bus.ResultSrcM), 32'(mResultSrc));
      check({tag, "/MemWriteM"},  32'(bus.MemWriteM),  32'(mMemWrite));
      check({tag, "/ALUResultM"}, bus.ALUResultM,      mAluResult);
      check({tag, "/WriteDataM"}, bus.WriteDataM,      mWriteData);
      check({tag, "/PCPlus4M"},   bus.PCPlus4M,        mPcPlus4);
      check({tag, "/RdM"},        32'(bus.RdM),        32'(mRd));
   endtask

   task automatic clearInputs();
      bus.RegWriteE   = 1'b0;
      bus.ResultSrcE  = 1'b0;
      bus.MemWriteE   = 1'b0;
      bus.BranchE     = 1'b0;
      bus.JumpE       = 1'b0;
      bus.ALUSrcE     = 1'b0;
      bus.ALUControlE = 3'd0;
      bus.RD1E        = '0;
      bus.RD2E        = '0;
      bus.ImmExtE     = '0;
      bus.PCE         = '0;
      bus.PCPlus4E    = '0;
      bus.RdE         = '0;
      bus.ForwardAE   = 2'd0;
      bus.ForwardBE   = 2'd0;
      bus.ResultW     = '0;
   endtask

   task automatic randomInputs();
      bus.RegWriteE   = 1'($urandom_range(0, 1));
      bus.ResultSrcE  = 1'($urandom_range(0, 1));
      bus.MemWriteE   = 1'($urandom_range(0, 1));
      bus.BranchE     = 1'($urandom_range(0, 1));
      bus.JumpE       = 1'($urandom_range(0, 3) == 0);
      bus.ALUSrcE     = 1'($urandom_range(0, 1));
      bus.ALUControlE = 3'($urandom_range(0, 7));
      bus.RD1E        = $urandom;
      bus.RD2E        = ($urandom_range(0, 3) == 0) ? bus.RD1E : $urandom;
      bus.ImmExtE     = $urandom;
      bus.PCE         = $urandom;
      bus.PCPlus4E    = bus.PCE + 32'd4;
      bus.RdE         = 5'($urandom_range(0, 31));
      bus.ForwardAE   = 2'($urandom_range(0, 3));
      bus.ForwardBE   = 2'($urandom_range(0, 3));
      bus.ResultW     = $urandom;
   endtask

   // Called just after a rising edge with E inputs already set. Checks the
   // same-cycle redirect, crosses one falling edge, checks the M outputs,
   // and returns just after the next rising edge.
   task automatic step(input string tag);
      logic [31:0] a, fb, b, res;
      logic        expSrc;
      #1;
      a      = refFwd(bus.ForwardAE, bus.RD1E, bus.ResultW, mAluResult);
      fb     = refFwd(bus.ForwardBE, bus.RD2E, bus.ResultW, mAluResult);
      b      = bus.ALUSrcE ? bus.ImmExtE : fb;
      res    = refAlu(bus.ALUControlE, a, b);
      expSrc = bus.JumpE || (bus.BranchE && res == 32'd0);
      check({tag, "/PCTargetE"}, bus.PCTargetE, bus.PCE + bus.ImmExtE);
      check({tag, "/PCSrcE"}, 32'(bus.PCSrcE), 32'(expSrc));
      @(negedge clk);
      if (rst) begin
         mRegWrite  = bus.RegWriteE;
         mResultSrc = bus.ResultSrcE;
         mMemWrite  = bus.MemWriteE;
         mAluResult = res;
         mWriteData = fb;
         mPcPlus4   = bus.PCPlus4E;
         mRd        = bus.RdE;
      end else begin
         modelClear();
      end
      #1;
      checkM(tag);
      @(posedge clk);
      #1;
   endtask

   initial begin
      modelClear();

      // Reset held with every E input non-zero
      rst = 1'b0;
      bus.RegWriteE = 1'b1; bus.ResultSrcE = 1'b1; bus.MemWriteE = 1'b1;
      bus.BranchE = 1'b1; bus.JumpE = 1'b1; bus.ALUSrcE = 1'b1;
      bus.ALUControlE = 3'd3; bus.RD1E = 32'h1234; bus.RD2E = 32'h55;
      bus.ImmExtE = 32'h77; bus.PCE = 32'h200; bus.PCPlus4E = 32'h204;
      bus.RdE = 5'd9; bus.ForwardAE = 2'd1; bus.ForwardBE = 2'd2;
      bus.ResultW = 32'h99;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         #1;
         checkM("reset_hold");
      end
      @(posedge clk);
      #1;
      rst = 1'b1;

      // Immediate ADD is the first instruction latched after release
      clearInputs();
      bus.RD1E = 32'd5; bus.ImmExtE = 32'd7; bus.ALUSrcE = 1'b1;
      bus.ALUControlE = 3'b000; bus.RdE = 5'd3; bus.RegWriteE = 1'b1;
      step("imm_add");
      check("imm_add/const_result", bus.ALUResultM, 32'd12);
      check("imm_add/const_rd", 32'(bus.RdM), 32'd3);
      check("imm_add/const_regwrite", 32'(bus.RegWriteM), 32'd1);

      // Forwarding: seed ALUResultM=0x10, then SUB MEM-bypass minus WB-bypass
      clearInputs();
      bus.RD1E = 32'h10; bus.ALUSrcE = 1'b1; bus.RegWriteE = 1'b1; bus.RdE = 5'd4;
      step("fwd_seed");
      clearInputs();
      bus.ForwardAE = 2'b10; bus.ForwardBE = 2'b01; bus.ResultW = 32'h20;
      bus.RD1E = 32'hDEAD; bus.RD2E = 32'hBEEF; bus.ALUControlE = 3'b001;
      step("fwd_sub");
      check("fwd_sub/const_result", bus.ALUResultM, 32'hFFFF_FFF0);
      check("fwd_sub/const_wdata", bus.WriteDataM, 32'h20);

      // BEQ taken, backward target
      clearInputs();
      bus.RD1E = 32'd9; bus.RD2E = 32'd9; bus.BranchE = 1'b1;
      bus.ALUControlE = 3'b001; bus.PCE = 32'h100; bus.ImmExtE = 32'hFFFF_FFF8;
      #1;
      check("beq_taken/const_pcsrc", 32'(bus.PCSrcE), 32'd1);
      check("beq_taken/const_target", bus.PCTargetE, 32'hF8);
      step("beq_taken");

      // BEQ not taken
      bus.RD2E = 32'd8;
      #1;
      check("beq_not/const_pcsrc", 32'(bus.PCSrcE), 32'd0);
      step("beq_not");

      // Signed SLT: -1 < 1
      clearInputs();
      bus.RD1E = 32'hFFFF_FFFF; bus.RD2E = 32'd1; bus.ALUControlE = 3'b101;
      bus.RegWriteE = 1'b1;
      step("slt");
      check("slt/const_result", bus.ALUResultM, 32'd1);

      // JAL redirects and carries the link address
      clearInputs();
      bus.JumpE = 1'b1; bus.PCPlus4E = 32'h44; bus.RegWriteE = 1'b1; bus.RdE = 5'd1;
      #1;
      check("jal/const_pcsrc", 32'(bus.PCSrcE), 32'd1);
      step("jal");
      check("jal/const_pcplus4", bus.PCPlus4M, 32'h44);

      // Randomized traffic, including the unused forward code 11
      for (int i = 0; i < 60; i++) begin
         randomInputs();
         step("rand");
      end

      // Asynchronous reset between edges while a store is in flight
      randomInputs();
      bus.MemWriteE = 1'b1;
      step("pre_reset_store");
      check("pre_reset_store/const_memwrite", 32'(bus.MemWriteM), 32'd1);
      rst = 1'b0;
      #1;
      modelClear();
      checkM("async_reset");
      step("during_reset");
      rst = 1'b1;
      for (int i = 0; i < 20; i++) begin
         randomInputs();
         step("rand_post");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
